// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: stalls for load-use, ID-resolved branch operands and
// mult/div busy conflicts; flushes IF/ID on taken control transfers; counts stall cycles.
module hazard_detection_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [31:0]          ID_Instruction,
    input  logic                 ID_IsBranch,
    input  logic                 ID_BranchTaken,
    input  logic                 ID_IsJump,
    input  logic                 EX_MemRead,
    input  logic                 EX_RegWrite,
    input  logic [4:0]           EX_WriteReg,
    input  logic                 MEM_MemRead,
    input  logic [4:0]           MEM_WriteReg,
    input  logic                 EX_StartMulDiv,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 IDEXBubble,
    output logic                 IFIDFlush,
    output logic                 MDBusy,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY);

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [9:0] unused_id_bits;

    assign id_rs          = ID_Instruction[25:21];
    assign id_rt          = ID_Instruction[20:16];
    assign id_opcode      = ID_Instruction[31:26];
    assign id_funct       = ID_Instruction[5:0];
    assign unused_id_bits = ID_Instruction[15:6];

    logic ex_match;
    logic mem_match;
    logic is_special;
    logic load_use;
    logic br_ex;
    logic br_ld;
    logic hilo;
    logic md_issue;
    logic stall;

    logic [5:0]           md_cnt_d,      md_cnt_q;
    logic [CNT_WIDTH-1:0] stall_count_d, stall_count_q;

    // $zero is hardwired, so a write to it can never feed an operand.
    assign ex_match   = (EX_WriteReg != 5'd0)  && (EX_WriteReg == id_rs  || EX_WriteReg == id_rt);
    assign mem_match  = (MEM_WriteReg != 5'd0) && (MEM_WriteReg == id_rs || MEM_WriteReg == id_rt);
    assign is_special = (id_opcode == 6'd0);

    assign load_use = EX_MemRead && ex_match;
    assign br_ex    = ID_IsBranch && EX_RegWrite && ex_match;
    assign br_ld    = ID_IsBranch && MEM_MemRead && mem_match;
    assign hilo     = MDBusy && is_special && (id_funct == 6'h10 || id_funct == 6'h12);
    assign md_issue = MDBusy && is_special && (id_funct >= 6'h18 && id_funct <= 6'h1B);
    assign stall    = load_use || br_ex || br_ld || hilo || md_issue;

    assign PCWrite    = !stall;
    assign IFIDWrite  = !stall;
    assign IDEXBubble = stall;
    // Branch operands are stale while stalled, so a flush must wait for the stall to clear.
    assign IFIDFlush  = !stall && ((ID_IsBranch && ID_BranchTaken) || ID_IsJump);

    assign MDBusy     = (md_cnt_q != 6'd0);
    assign StallCount = stall_count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        md_cnt_d      = md_cnt_q;
        stall_count_d = stall_count_q;

        if (EX_StartMulDiv) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != 6'd0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end

        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            md_cnt_q      <= 6'd0;
            stall_count_q <= '0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-indexed behavioural model.
module tb_hazard_detection_unit;

    localparam int L  = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (2 ** CW) - 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [31:0]   ID_Instruction;
    logic          ID_IsBranch;
    logic          ID_BranchTaken;
    logic          ID_IsJump;
    logic          EX_MemRead;
    logic          EX_RegWrite;
    logic [4:0]    EX_WriteReg;
    logic          MEM_MemRead;
    logic [4:0]    MEM_WriteReg;
    logic          EX_StartMulDiv;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          IDEXBubble;
    logic          IFIDFlush;
    logic          MDBusy;
    logic [CW-1:0] StallCount;

    hazard_detection_unit #(.MD_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ID_Instruction (ID_Instruction),
        .ID_IsBranch    (ID_IsBranch),
        .ID_BranchTaken (ID_BranchTaken),
        .ID_IsJump      (ID_IsJump),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWrite    (EX_RegWrite),
        .EX_WriteReg    (EX_WriteReg),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_WriteReg   (MEM_WriteReg),
        .EX_StartMulDiv (EX_StartMulDiv),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEXBubble     (IDEXBubble),
        .IFIDFlush      (IFIDFlush),
        .MDBusy         (MDBusy),
        .StallCount     (StallCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cycle index, cycle of the most recent mult/div start, stall total.
    int cyc        = 0;
    int last_start = 0;
    bit has_start  = 1'b0;
    int exp_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [5:0] fn);
        return {op, rs, rt, 10'd0, fn};
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && (r == ID_Instruction[25:21] || r == ID_Instruction[20:16]);
    endfunction

    // Busy for the L cycles strictly after the most recent start.
    function automatic bit model_busy();
        return has_start && (cyc <= last_start + L);
    endfunction

    function automatic bit model_stall();
        bit special;
        int fn;
        special = (ID_Instruction[31:26] == 6'd0);
        fn      = int'(ID_Instruction[5:0]);
        if (EX_MemRead && reads(EX_WriteReg)) return 1'b1;
        if (ID_IsBranch && EX_RegWrite && reads(EX_WriteReg)) return 1'b1;
        if (ID_IsBranch && MEM_MemRead && reads(MEM_WriteReg)) return 1'b1;
        if (model_busy() && special && (fn == 'h10 || fn == 'h12)) return 1'b1;
        if (model_busy() && special && fn >= 'h18 && fn <= 'h1B) return 1'b1;
        return 1'b0;
    endfunction

    task automatic quiet();
        ID_Instruction = mk(6'd0, 5'd0, 5'd0, 6'h20);
        ID_IsBranch    = 1'b0;
        ID_BranchTaken = 1'b0;
        ID_IsJump      = 1'b0;
        EX_MemRead     = 1'b0;
        EX_RegWrite    = 1'b0;
        EX_WriteReg    = 5'd0;
        MEM_MemRead    = 1'b0;
        MEM_WriteReg   = 5'd0;
        EX_StartMulDiv = 1'b0;
    endtask

    task automatic model_reset();
        has_start = 1'b0;
        exp_cnt   = 0;
    endtask

    // Entered 1 time unit after a rising edge with inputs already applied.
    task automatic cycle_check(input string tag);
        bit st;
        bit fl;
        #1;
        st = model_stall();
        fl = !st && ((ID_IsBranch && ID_BranchTaken) || ID_IsJump);
        check({tag, ".pcw"},    PCWrite,    !st);
        check({tag, ".ifidw"},  IFIDWrite,  !st);
        check({tag, ".bubble"}, IDEXBubble, st);
        check({tag, ".flush"},  IFIDFlush,  fl);
        check({tag, ".busy"},   MDBusy,     model_busy());
        check({tag, ".cnt"},    StallCount, exp_cnt);
        @(posedge Clock);
        if (!Reset) begin
            if (st && exp_cnt < CNT_MAX) exp_cnt++;
            if (EX_StartMulDiv) begin
                last_start = cyc;
                has_start  = 1'b1;
            end
            cyc++;
        end
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; must clear state before any edge.
    task automatic mid_reset(input string tag);
        #1;
        Reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".busy"}, MDBusy, 0);
        check({tag, ".cnt"},  StallCount, 0);
        quiet();
        #1;
        check({tag, ".pcw"},  PCWrite, 1);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    logic [5:0] fn_tab [8] = '{6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h11};

    initial begin
        Reset = 1'b1;
        quiet();
        #12;
        check("rst.pcw",    PCWrite,    1);
        check("rst.ifidw",  IFIDWrite,  1);
        check("rst.bubble", IDEXBubble, 0);
        check("rst.flush",  IFIDFlush,  0);
        check("rst.busy",   MDBusy,     0);
        check("rst.cnt",    StallCount, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Load-use: lw $8 in EX, add $9,$8,$10 in ID.
        quiet();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
        ID_Instruction = mk(6'd0, 5'd8, 5'd10, 6'h20);
        cycle_check("ld_use");
        quiet();
        MEM_MemRead = 1'b1; MEM_WriteReg = 5'd8;
        ID_Instruction = mk(6'd0, 5'd8, 5'd10, 6'h20);
        cycle_check("ld_use_after");
        check("ld_use_total", StallCount, 1);

        // Load into $zero never stalls.
        quiet();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd0;
        cycle_check("zero");
        quiet();
        #1;
        check("zero_total", StallCount, 1);
        #1;
        @(posedge Clock);
        cyc++;
        #1;

        // Branch on a loaded register: two stall cycles, then the taken flush.
        quiet();
        ID_Instruction = mk(6'd4, 5'd4, 5'd5, 6'd0);
        ID_IsBranch = 1'b1; ID_BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd4;
        cycle_check("br_ld1");
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteReg = 5'd4;
        cycle_check("br_ld2");
        MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
        #1;
        check("br_ld3_flush", IFIDFlush, 1);
        check("br_ld3_total", StallCount, 3);
        #1;
        cycle_check("br_ld3");

        // ALU result feeding a taken branch: stall must suppress the flush.
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd5;
        #1;
        check("stall_beats_flush.flush",  IFIDFlush,  0);
        check("stall_beats_flush.bubble", IDEXBubble, 1);
        #1;
        cycle_check("stall_beats_flush");

        quiet();
        ID_IsJump = 1'b1;
        cycle_check("jump");

        // Mult/div start then mfhi held: stalls for exactly L cycles.
        quiet();
        EX_StartMulDiv = 1'b1;
        cycle_check("md_start");
        quiet();
        ID_Instruction = mk(6'd0, 5'd0, 5'd0, 6'h10);
        for (int i = 1; i <= L; i++) begin
            #1;
            check($sformatf("md_hold%0d", i), IDEXBubble, 1);
            #1;
            cycle_check($sformatf("md_t%0d", i));
        end
        #1;
        check("md_release", IDEXBubble, 0);
        #1;
        cycle_check("md_t5");

        // Re-issue two cycles after the first start extends busy by two cycles.
        quiet();
        EX_StartMulDiv = 1'b1;
        cycle_check("md2_start");
        EX_StartMulDiv = 1'b0;
        ID_Instruction = mk(6'd0, 5'd0, 5'd0, 6'h10);
        cycle_check("md2_t1");
        EX_StartMulDiv = 1'b1;
        cycle_check("md2_t2");
        EX_StartMulDiv = 1'b0;
        for (int i = 3; i <= L + 3; i++) cycle_check($sformatf("md2_t%0d", i));

        // Reset while md_cnt is mid-countdown and the pipe is stalling on mflo.
        quiet();
        EX_StartMulDiv = 1'b1;
        cycle_check("rst_md_start");
        EX_StartMulDiv = 1'b0;
        ID_Instruction = mk(6'd0, 5'd0, 5'd0, 6'h12);
        cycle_check("rst_md_t1");
        #1;
        check("rst_md_stalling", IDEXBubble, 1);
        mid_reset("rst_md");
        cycle_check("post_rst");

        // Randomized traffic over a small register range to make matches frequent.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'd4 : 6'd0;
            ID_Instruction = mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                fn_tab[$urandom_range(0, 7)]);
            ID_IsBranch    = (op == 6'd4);
            ID_BranchTaken = 1'($urandom_range(0, 1));
            ID_IsJump      = (op == 6'd0) && ($urandom_range(0, 7) == 0);
            EX_MemRead     = ($urandom_range(0, 2) == 0);
            EX_RegWrite    = EX_MemRead || ($urandom_range(0, 1) == 1);
            EX_WriteReg    = 5'($urandom_range(0, 3));
            MEM_MemRead    = ($urandom_range(0, 2) == 0);
            MEM_WriteReg   = 5'($urandom_range(0, 3));
            EX_StartMulDiv = ($urandom_range(0, 9) == 0);
            cycle_check($sformatf("rnd%0d", n));
            if ($urandom_range(0, 99) == 0) mid_reset($sformatf("rnd_rst%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Hazard detection stage that sits in ID, directly upstream of the EX-stage operand forwarding logic.
- Resolves the hazards that forwarding alone cannot cover:
  - load-use dependencies
  - branch operands computed in ID
  - HI/LO reads or new mult/div issued while the multi-cycle mult/div unit is busy
- Drives PC/IF-ID write enables, inserts ID/EX bubbles, flushes IF/ID on taken control transfers, and keeps a stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32, number of cycles the mult/div unit is busy after issue (legal range 1..63).
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Instruction  in  32  instruction in ID: rs=[25:21], rt=[20:16], opcode=[31:26], funct=[5:0].
- ID_IsBranch  in  1  ID instruction is beq/bne (compares rs/rt in ID).
- ID_BranchTaken  in  1  branch comparator outcome in ID; only meaningful when ID_IsBranch=1.
- ID_IsJump  in  1  ID instruction is j/jal/jr.
- EX_MemRead  in  1  EX instruction is a load.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_WriteReg  in  5  EX destination register.
- MEM_MemRead  in  1  MEM instruction is a load.
- MEM_WriteReg  in  5  MEM destination register.
- EX_StartMulDiv  in  1  mult/multu/div/divu is in EX this cycle.
- PCWrite  out  1  1 = PC may update.
- IFIDWrite  out  1  1 = IF/ID register may load.
- IDEXBubble  out  1  1 = ID/EX loads a NOP (all control zero).
- IFIDFlush  out  1  1 = IF/ID loads a NOP.
- MDBusy  out  1  mult/div unit busy.
- StallCount  out  CNT_WIDTH  total cycles stalled since reset; saturates at all-ones.

Behaviour:
- Source match: match(r) = (r != 0) && (r == ID rs || r == ID rt). Register 0 never causes a hazard.
- Stall conditions (combinational, same cycle):
  - load_use = EX_MemRead && match(EX_WriteReg)
  - br_ex = ID_IsBranch && EX_RegWrite && match(EX_WriteReg)
  - br_ld = ID_IsBranch && MEM_MemRead && match(MEM_WriteReg)
  - hilo = MDBusy && opcode==0 && funct in {0x10, 0x12}
  - md_issue = MDBusy && opcode==0 && funct in {0x18..0x1B}
  - stall = OR of all five conditions.
- A branch depending on a load in EX therefore stalls 2 cycles: br_ex or load_use first, then br_ld.
- Output equations:
  - PCWrite = IFIDWrite = !stall
  - IDEXBubble = stall
  - IFIDFlush = !stall && ((ID_IsBranch && ID_BranchTaken) || ID_IsJump)
  - Stall has priority: no flush while stalled, because branch operands are not yet valid.
- Mult/div counter md_cnt (6 bits):
  - Reset -> 0.
  - EX_StartMulDiv=1 -> load MD_LATENCY. This takes precedence over decrement, including when already busy.
  - Else if md_cnt != 0 -> decrement.
  - MDBusy = (md_cnt != 0), decoded from the register; no combinational path from EX_StartMulDiv.
  - Start in cycle T gives MDBusy=1 for cycles T+1..T+MD_LATENCY, and 0 at T+MD_LATENCY+1.
- StallCount:
  - Reset -> 0.
  - Increments on each rising edge where stall=1.
  - Holds at 2^CNT_WIDTH-1 (no wrap).
- Reset asserted at any time, including mid-stall or mid-mult/div:
  - Clears md_cnt and StallCount immediately (asynchronous).
  - Outputs then follow the combinational equations with MDBusy=0.
  - With quiescent inputs after reset: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, MDBusy=0, StallCount=0.
- All inputs X-free after reset; no latches; outputs combinational except MDBusy and StallCount.

Test Plan:
- Load-use: EX lw $8 (EX_MemRead=1, EX_WriteReg=8); ID add $9,$8,$10 (rs=8) -> PCWrite=0, IDEXBubble=1 for exactly 1 cycle; StallCount 0->1.
- $zero: EX_MemRead=1, EX_WriteReg=0, ID rs=0 -> no stall, PCWrite=1.
- Branch after load:
  - cycle 1: EX lw $4, ID beq $4,$5 -> stall.
  - cycle 2: load in MEM (MEM_WriteReg=4) -> stall.
  - cycle 3: no stall; with ID_BranchTaken=1, IFIDFlush=1; StallCount=2.
- Stall beats flush: ID_IsBranch=1, ID_BranchTaken=1, EX_RegWrite=1, EX_WriteReg=rt -> IFIDFlush=0, IDEXBubble=1.
- Mult/div with MD_LATENCY=4: EX_StartMulDiv pulse at T; ID mfhi held -> stall T+1..T+4, released T+5; re-pulse at T+2 extends busy through T+6.
- Async reset while md_cnt=3 and stalling -> MDBusy=0 and StallCount=0 immediately, before the next clock edge.
